// File: rtl/dmem_lsu_pkg.sv
// Purpose : shared types, funct3 codes and access-classification helpers for the LSU.
// Latency : n/a (declarations and pure functions only).
// Backpr. : n/a.
package dmem_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RESP = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // An access crosses into the next word when its last byte lands past lane 3.
    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] off);
        logic res;
        res = 1'b0;
        case (funct3[1:0])
            2'b01:   res = (off == 2'b11);
            2'b10:   res = (off != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic res;
        res = 1'b0;
        if (we) begin
            res = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            res = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                  (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_lsu_master_if.sv
// Purpose : CPU request/response handshake plus word-memory port of the LSU.
// Latency : n/a (wiring only).
// Backpr. : req_valid/req_ready on the CPU side; memory side has none (combinational read).
// Ports   : master = LSU view (drives req_ready, resp_*, mem_addr/wen/wdata);
//           slave  = CPU + memory view (drives req_*, mem_rdata).
interface dmem_lsu_master_if #(
    parameter int ADDRESS_WIDTH = 20
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [2:0]               req_funct3;
    logic [31:0]              req_addr;
    logic [31:0]              req_wdata;
    logic                     resp_valid;
    logic [31:0]              resp_rdata;
    logic                     resp_err;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_wen;
    logic [31:0]              mem_wdata;
    logic [31:0]              mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu_master_lane_align.sv
// Purpose : byte-lane merge of store data into {buf1,buf0} and load extract/extend from it.
// Latency : combinational.
// Backpr. : none.
// Ports   : funct3/off select size and lane; wdata = store data; buf0/buf1 = captured words;
//           wr_word0/wr_word1 = merged write words; ld_data = extended load result.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] buf0,
    input  logic [31:0] buf1,
    output logic [31:0] wr_word0,
    output logic [31:0] wr_word1,
    output logic [31:0] ld_data
);
    logic [63:0] pair;
    logic [31:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] st_data;
    logic [63:0] merged;
    logic [31:0] shifted;
    logic [5:0]  shamt;

    // Treat the two words as one 64-bit little-endian window so a crossing
    // access is just a shift by the byte offset, with no per-case lane logic.
    always_comb begin
        pair  = {buf1, buf0};
        shamt = {1'b0, off, 3'b000};
        case (funct3[1:0])
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        lane_mask = {32'h0, size_mask} << shamt;
        st_data   = {32'h0, wdata} << shamt;
        merged    = (pair & ~lane_mask) | (st_data & lane_mask);
        wr_word0  = merged[31:0];
        wr_word1  = merged[63:32];

        shifted = 32'(pair >> shamt);
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end
endmodule

// File: rtl/dmem_lsu_master.sv
// Purpose : RV32I load/store sequencer onto a word memory (RMW for sub-word stores, two-word splits).
// Latency : accept->resp 1 (illegal), 2 (aligned load / aligned SW), 3 (split load, in-word SB/SH), 5 (split store).
// Backpr. : req_ready only in IDLE; one bubble cycle after each response; resp has no backpressure.
// Ports   : clk, rst_n (sync active-low); bus = dmem_lsu_master_if.master (req_*, resp_*, mem_*).
module dmem_lsu_master
    import dmem_lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_lsu_master_if.master    bus
);
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("dmem_lsu_master: DATA_WIDTH must be 32");
        end
    endgenerate

    lsu_state_e               state_q, state_d;
    logic                     we_q;
    logic [2:0]               f3_q;
    logic [ADDRESS_WIDTH+1:0] addr_q;
    logic [31:0]              wdata_q;
    logic                     err_q;
    logic [31:0]              buf0_q, buf1_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_c;
    logic [31:0]              mem_wdata_q, mem_wdata_c;

    logic [1:0]               off;
    logic [ADDRESS_WIDTH-1:0] w0, w1;
    logic                     split;
    logic                     accept;
    logic                     req_legal;
    logic                     req_aligned_sw;
    logic [31:0]              wr_word0, wr_word1, ld_data;

    // Address bits above the memory window are deliberately ignored.
    generate
        if (ADDRESS_WIDTH < 30) begin : g_addr_hi
            logic addr_hi_unused;
            assign addr_hi_unused = ^bus.req_addr[31:ADDRESS_WIDTH+2];
        end
    endgenerate

    assign off            = addr_q[1:0];
    assign w0             = addr_q[ADDRESS_WIDTH+1:2];
    assign w1             = w0 + ADDRESS_WIDTH'(1);   // wraps to word 0 at the top
    assign split          = is_split(f3_q, off);
    assign accept         = (state_q == ST_IDLE) && bus.req_valid;
    assign req_legal      = is_legal(bus.req_we, bus.req_funct3);
    assign req_aligned_sw = bus.req_we && (bus.req_funct3 == F3_W) && (bus.req_addr[1:0] == 2'b00);

    lsu_lane_align u_align (
        .funct3   (f3_q),
        .off      (off),
        .wdata    (wdata_q),
        .buf0     (buf0_q),
        .buf1     (buf1_q),
        .wr_word0 (wr_word0),
        .wr_word1 (wr_word1),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            buf0_q      <= 32'h0;
            buf1_q      <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr[ADDRESS_WIDTH+1:0];
                wdata_q <= bus.req_wdata;
                err_q   <= !req_legal;
            end
            if (state_q == ST_RD0) buf0_q <= bus.mem_rdata;
            if (state_q == ST_RD1) buf1_q <= bus.mem_rdata;
            // Hold registers let the memory port keep its last address/data while idle.
            mem_addr_q  <= mem_addr_c;
            mem_wdata_q <= mem_wdata_c;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.mem_wen    = 1'b0;
        mem_addr_c     = mem_addr_q;
        mem_wdata_c    = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!req_legal)          state_d = ST_RESP;
                    else if (req_aligned_sw) state_d = ST_WR0;
                    else                     state_d = ST_RD0;
                end
            end
            ST_RD0: begin
                mem_addr_c = w0;
                if (split)     state_d = ST_RD1;
                else if (we_q) state_d = ST_WR0;
                else           state_d = ST_RESP;
            end
            ST_RD1: begin
                mem_addr_c = w1;
                state_d    = we_q ? ST_WR0 : ST_RESP;
            end
            ST_WR0: begin
                bus.mem_wen = 1'b1;
                mem_addr_c  = w0;
                mem_wdata_c = wr_word0;
                state_d     = split ? ST_WR1 : ST_RESP;
            end
            ST_WR1: begin
                bus.mem_wen = 1'b1;
                mem_addr_c  = w1;
                mem_wdata_c = wr_word1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || we_q) ? 32'h0 : ld_data;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        bus.mem_addr  = mem_addr_c;
        bus.mem_wdata = mem_wdata_c;
    end
endmodule

// File: tb/tb_dmem_lsu_master.sv
// Purpose : directed self-checking bench for dmem_lsu_master with a small word-memory model.
// Latency : measured per request from the accept edge to the response cycle.
// Backpr. : bench issues one request at a time and waits for its response.
module tb_dmem_lsu_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_master_if #(.ADDRESS_WIDTH(20)) bus ();

    dmem_lsu_master #(.ADDRESS_WIDTH(20), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Mini memory: low 6 bits of the word index (0x10, 0x11, 0xFFFFF and 0 do not alias).
    logic [31:0] mem [64];
    logic        pl_en  = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_dat = 32'h0;
    int          wen_total  = 0;
    int          resp_total = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

    always @(posedge clk) begin
        if (pl_en)            mem[pl_idx] <= pl_dat;
        else if (bus.mem_wen) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        if (bus.mem_wen)    wen_total  <= wen_total + 1;
        if (bus.resp_valid) resp_total <= resp_total + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic err);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        rd   = 32'hXXXX_XXXX;
        err  = 1'bx;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        // Scramble the request fields while not valid; the DUT must use its latched copy.
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h5A5A_5A5A;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin
                seen = 1'b1;
                rd   = bus.resp_rdata;
                err  = bus.resp_err;
            end
        end
        check("resp_seen", {31'h0, seen}, 32'h1);
        @(negedge clk);
        check("resp_one_cycle", {31'h0, bus.resp_valid}, 32'h0);
        check("ready_after_resp", {31'h0, bus.req_ready}, 32'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int          lat;
    logic [31:0] rd;
    logic        err;
    int          w_before;
    int          r_before;

    initial begin
        // A legal request held during reset must not be accepted.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0044;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_err",   {31'h0, bus.resp_err},   32'h0);
        check("rst_resp_rdata", bus.resp_rdata,          32'h0);
        check("rst_mem_wen",    {31'h0, bus.mem_wen},    32'h0);
        check("rst_mem_addr",   {12'h0, bus.mem_addr},   32'h0);
        check("rst_mem_wdata",  bus.mem_wdata,           32'h0);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        // 1: byte loads, signed and unsigned
        preload(6'd16, 32'h8899_AABB);
        preload(6'd17, 32'h4433_2211);
        do_req(1'b0, 3'b000, 32'h41, 32'h0, lat, rd, err);
        check("lb_rdata", rd, 32'hFFFF_FFAA);
        check("lb_lat", lat, 32'd2);
        check("lb_err", {31'h0, err}, 32'h0);
        do_req(1'b0, 3'b100, 32'h41, 32'h0, lat, rd, err);
        check("lbu_rdata", rd, 32'h0000_00AA);

        // 2: in-word SB read-modify-write
        w_before = wen_total;
        do_req(1'b1, 3'b000, 32'h43, 32'hCAFE_0011, lat, rd, err);
        check("sb_mem", mem[16], 32'h1199_AABB);
        check("sb_wen_pulses", wen_total - w_before, 32'd1);
        check("sb_lat", lat, 32'd3);
        check("sb_rdata", rd, 32'h0);

        // 3: split loads
        preload(6'd16, 32'h8899_AABB);
        do_req(1'b0, 3'b010, 32'h42, 32'h0, lat, rd, err);
        check("lw_split_rdata", rd, 32'h2211_8899);
        check("lw_split_lat", lat, 32'd3);
        do_req(1'b0, 3'b001, 32'h43, 32'h0, lat, rd, err);
        check("lh_split_rdata", rd, 32'h0000_1188);
        check("lh_split_lat", lat, 32'd3);

        // 4: split SW
        w_before = wen_total;
        do_req(1'b1, 3'b010, 32'h41, 32'hDEAD_BEEF, lat, rd, err);
        check("sw_split_w0", mem[16], 32'hADBE_EFBB);
        check("sw_split_w1", mem[17], 32'h4433_22DE);
        check("sw_split_wen_pulses", wen_total - w_before, 32'd2);
        check("sw_split_lat", lat, 32'd5);
        check("idle_hold_addr",  {12'h0, bus.mem_addr}, 32'h11);
        check("idle_hold_wdata", bus.mem_wdata, 32'h4433_22DE);
        check("idle_wen", {31'h0, bus.mem_wen}, 32'h0);

        // In-word halfword loads: negative sign extension and zero extension
        do_req(1'b0, 3'b001, 32'h42, 32'h0, lat, rd, err);
        check("lh_neg_rdata", rd, 32'hFFFF_ADBE);
        check("lh_neg_lat", lat, 32'd2);
        do_req(1'b0, 3'b101, 32'h42, 32'h0, lat, rd, err);
        check("lhu_rdata", rd, 32'h0000_ADBE);

        // Aligned SW skips the read
        w_before = wen_total;
        do_req(1'b1, 3'b010, 32'h44, 32'h1234_5678, lat, rd, err);
        check("sw_aligned_mem", mem[17], 32'h1234_5678);
        check("sw_aligned_lat", lat, 32'd2);
        check("sw_aligned_wen_pulses", wen_total - w_before, 32'd1);

        // 5: illegal funct3
        w_before = wen_total;
        do_req(1'b0, 3'b011, 32'h40, 32'h0, lat, rd, err);
        check("ill_ld_err", {31'h0, err}, 32'h1);
        check("ill_ld_rdata", rd, 32'h0);
        check("ill_ld_lat", lat, 32'd1);
        do_req(1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, lat, rd, err);
        check("ill_st_err", {31'h0, err}, 32'h1);
        check("ill_st_lat", lat, 32'd1);
        check("ill_no_wen", wen_total - w_before, 32'd0);
        check("ill_mem_untouched", mem[16], 32'hADBE_EFBB);

        // 6a: reset during WR1 of a split SW
        preload(6'd16, 32'h0);
        preload(6'd17, 32'h0);
        r_before = resp_total;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h41;
        bus.req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);   // RD0, RD1, WR0, WR1
        check("wr1_wen",  {31'h0, bus.mem_wen}, 32'h1);
        check("wr1_addr", {12'h0, bus.mem_addr}, 32'h11);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rstmid_w0_committed", mem[16], 32'hADBE_EF00);
        check("rstmid_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_resp", resp_total - r_before, 32'd0);

        // 6b: split LW at the top word wraps to word 0
        preload(6'd63, 32'hDDCC_BBAA);
        preload(6'd0,  32'h0000_1122);
        do_req(1'b0, 3'b010, 32'h003F_FFFE, 32'h0, lat, rd, err);
        check("wrap_lw_rdata", rd, 32'h1122_DDCC);
        check("wrap_lw_lat", lat, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
